// File: rtl/uart_tx_dev_if.sv
`timescale 1ns/1ps
// Bus-side access port of the UART transmitter.
// The decoder (master) strobes uart_cen for one cycle per access; the
// transmitter (slave) answers with a combinational uart_error in that cycle.
interface uart_tx_dev_if;
    logic       uart_cen;
    logic       uart_wr;
    logic [7:0] uart_wdata;
    logic       uart_error;

    modport master (
        output uart_cen,
        output uart_wr,
        output uart_wdata,
        input  uart_error
    );

    modport slave (
        input  uart_cen,
        input  uart_wr,
        input  uart_wdata,
        output uart_error
    );
endinterface

// File: rtl/uart_tx_dev.sv
`timescale 1ns/1ps
// UART transmitter with a small write FIFO.
// Bytes written over the bus are queued and shifted out on txd as
// 8N1 frames (start, 8 data bits LSB first, stop), each bit CLK_DIV clocks.
// Define UART_PARITY_EN to insert an even-parity bit before the stop bit
// (8E1, 11-bit frames).
// txd is registered one cycle behind the FSM state so that the line never
// glitches; a pop at edge N shows the start bit from edge N+1.
module uart_tx_dev #(
    parameter int unsigned CLK_DIV = 16,
    parameter int unsigned DEPTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    uart_tx_dev_if.slave           bus,
    output logic                   txd,
    output logic                   tx_busy,
    output logic [$clog2(DEPTH):0] tx_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(CLK_DIV);

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             fifoFull;
    logic             fifoEmpty;
    logic             push;
    logic             pop;

    // Transmit engine
    state_t           state_q, state_d;
    logic [CNT_W-1:0] baudCnt_q, baudCnt_d;
    logic [2:0]       bitIdx_q, bitIdx_d;
    logic [7:0]       shiftReg_q, shiftReg_d;
    logic             txd_q, txd_d;
    logic             bitDone;

    assign fifoFull  = (level_q == LVL_FULL);
    assign fifoEmpty = (level_q == '0);
    assign bitDone   = (baudCnt_q == BAUD_LAST);

    // A write is taken only when there is room; full is judged on the
    // occupancy at the start of the cycle, so a simultaneous pop does not help.
    assign push = bus.uart_cen && bus.uart_wr && !fifoFull;

    // Reads are unsupported and writes to a full FIFO are dropped; both flag
    // an error for the duration of the strobe only.
    always_comb begin
        bus.uart_error = bus.uart_cen && (!bus.uart_wr || fifoFull);
    end

    // Next FIFO pointers and occupancy; push and pop together leave the level alone.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        level_d = level_q;
        if (push) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end
    end

    // FIFO data array; no reset needed because level_q gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr_q] <= bus.uart_wdata;
        end
    end

    // FIFO pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            level_q <= level_d;
        end
    end

    // Frame sequencer: decides the next state, when to pop, and the line level.
    always_comb begin
        state_d    = state_q;
        baudCnt_d  = baudCnt_q;
        bitIdx_d   = bitIdx_q;
        shiftReg_d = shiftReg_q;
        pop        = 1'b0;
        txd_d      = 1'b1;

        unique case (state_q)
            IDLE: begin
                baudCnt_d = '0;
                bitIdx_d  = '0;
                if (!fifoEmpty) begin
                    pop     = 1'b1;
                    state_d = START;
                end
            end

            START: begin
                txd_d = 1'b0;
                if (bitDone) begin
                    baudCnt_d = '0;
                    bitIdx_d  = '0;
                    state_d   = DATA;
                end else begin
                    baudCnt_d = baudCnt_q + 1'b1;
                end
            end

            DATA: begin
                txd_d = shiftReg_q[bitIdx_q];
                if (bitDone) begin
                    baudCnt_d = '0;
                    if (bitIdx_q == 3'd7) begin
                        bitIdx_d = '0;
`ifdef UART_PARITY_EN
                        state_d  = PARITY;
`else
                        state_d  = STOP;
`endif
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end else begin
                    baudCnt_d = baudCnt_q + 1'b1;
                end
            end

`ifdef UART_PARITY_EN
            PARITY: begin
                txd_d = ^shiftReg_q;
                if (bitDone) begin
                    baudCnt_d = '0;
                    state_d   = STOP;
                end else begin
                    baudCnt_d = baudCnt_q + 1'b1;
                end
            end
`endif

            STOP: begin
                txd_d = 1'b1;
                if (bitDone) begin
                    baudCnt_d = '0;
                    if (!fifoEmpty) begin
                        pop     = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baudCnt_d = baudCnt_q + 1'b1;
                end
            end

            default: begin
                baudCnt_d = '0;
                bitIdx_d  = '0;
                state_d   = IDLE;
            end
        endcase

        if (pop) begin
            shiftReg_d = mem[rdPtr_q];
        end
    end

    // Frame sequencer registers, including the registered serial line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            baudCnt_q  <= '0;
            bitIdx_q   <= '0;
            shiftReg_q <= '0;
            txd_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            baudCnt_q  <= baudCnt_d;
            bitIdx_q   <= bitIdx_d;
            shiftReg_q <= shiftReg_d;
            txd_q      <= txd_d;
        end
    end

    assign txd      = txd_q;
    assign tx_busy  = (state_q != IDLE) || (level_q != '0);
    assign tx_level = level_q;

endmodule

// File: tb/tb_uart_tx_dev.sv
`timescale 1ns/1ps
// Self-checking bench for uart_tx_dev (CLK_DIV=4, DEPTH=8).
// Accepted writes push the expected byte into a queue; an independent line
// monitor decodes frames from txd and compares them against that queue.
// Directed cycle-level checks cover timing, errors, overflow and reset.
module tb_uart_tx_dev;

    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 8;
`ifdef UART_PARITY_EN
    localparam int NBITS   = 11;
`else
    localparam int NBITS   = 10;
`endif
    localparam int FRAME_CYC = NBITS * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       txd;
    logic       tx_busy;
    logic [3:0] tx_level;

    uart_tx_dev_if busIf();

    uart_tx_dev #(
        .CLK_DIV (CLK_DIV),
        .DEPTH   (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (busIf),
        .txd      (txd),
        .tx_busy  (tx_busy),
        .tx_level (tx_level)
    );

    always #5 clk = ~clk;

    int         nCompared   = 0;
    int         nMismatched = 0;
    logic [7:0] expQ [$];
    bit         resetSeen   = 1'b0;
    bit         monBusy     = 1'b0;

    // Any reset pulse invalidates the frame the monitor is decoding.
    always @(negedge rst_n) resetSeen = 1'b1;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: actual=%0h required=%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // One bus access cycle; caller is just after a rising edge, returns 1ns after the access edge.
    task automatic applyStimulus(input logic wr, input logic [7:0] data, input logic expErr);
        string nm;
        nm = wr ? "writeError" : "readError";
        busIf.uart_cen   = 1'b1;
        busIf.uart_wr    = wr;
        busIf.uart_wdata = data;
        @(negedge clk);
        checkOutput(nm, 32'(busIf.uart_error), 32'(expErr));
        if (wr && !expErr) expQ.push_back(data);
        @(posedge clk);
        #1;
        busIf.uart_cen = 1'b0;
        busIf.uart_wr  = 1'b0;
    endtask

    // Bounded wait until every queued byte has been seen and the DUT is idle.
    task automatic waitDrain(input int budget);
        int c;
        c = 0;
        while ((expQ.size() != 0 || tx_busy !== 1'b0 || monBusy) && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        checkOutput("drainInBudget", 32'(c < budget), 32'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Write one byte to an idle DUT and check txd/tx_busy on every cycle of the frame.
    task automatic traceFrame(input logic [7:0] data, input logic par);
        logic [10:0] fr;
        logic        expTxd;
        logic        expBusy;
        fr = {1'b1, par, data, 1'b0};
        if (NBITS == 10) fr[9] = 1'b1;
        applyStimulus(1'b1, data, 1'b0);
        for (int k = 1; k <= FRAME_CYC + 3; k++) begin
            @(posedge clk);
            #1;
            expTxd  = (k >= 2 && k <= FRAME_CYC + 1) ? fr[(k - 2) / CLK_DIV] : 1'b1;
            expBusy = (k <= FRAME_CYC) ? 1'b1 : 1'b0;
            checkOutput($sformatf("trace%02h_txd_k%0d", data, k), 32'(txd), 32'(expTxd));
            checkOutput($sformatf("trace%02h_busy_k%0d", data, k), 32'(tx_busy), 32'(expBusy));
        end
    endtask

    // Wait n falling edges; gives up early if a reset has been seen.
    task automatic monWait(input int n, output bit aborted);
        aborted = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (resetSeen) begin
                aborted = 1'b1;
                return;
            end
        end
    endtask

    // Line monitor: decode each frame at mid-bit and score it against the queue.
    initial begin : lineMonitor
        logic [7:0] got;
        logic [7:0] exp;
        logic       parBit;
        logic       stopBit;
        bit         ab;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && txd === 1'b0) begin
                resetSeen = 1'b0;
                monBusy   = 1'b1;
                got       = '0;
                parBit    = 1'b0;
                monWait(CLK_DIV / 2, ab);
                if (!ab) checkOutput("monStartBit", 32'(txd), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    if (!ab) begin
                        monWait(CLK_DIV, ab);
                        got[i] = txd;
                    end
                end
                if (!ab && NBITS == 11) begin
                    monWait(CLK_DIV, ab);
                    parBit = txd;
                end
                stopBit = 1'b0;
                if (!ab) begin
                    monWait(CLK_DIV, ab);
                    stopBit = txd;
                end
                if (!ab) begin
                    checkOutput("monStopBit", 32'(stopBit), 32'd1);
                    if (expQ.size() == 0) begin
                        checkOutput("monUnexpectedFrame", 32'(got), 32'hFFFF_FFFF);
                    end else begin
                        exp = expQ.pop_front();
                        checkOutput("monFrameData", 32'(got), 32'(exp));
                        if (NBITS == 11) checkOutput("monParity", 32'(parBit), 32'(^exp));
                    end
                end
                monBusy = 1'b0;
            end
        end
    end

    // Absolute time limit so the run always ends.
    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin : stimulus
        logic tr [200];
        int   f1;

        busIf.uart_cen   = 1'b0;
        busIf.uart_wr    = 1'b0;
        busIf.uart_wdata = 8'h00;
        rst_n            = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetTxd",   32'(txd),              32'd1);
        checkOutput("resetBusy",  32'(tx_busy),          32'd0);
        checkOutput("resetLevel", 32'(tx_level),         32'd0);
        checkOutput("resetError", 32'(busIf.uart_error), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] single frame 0x55 with cycle trace");
        traceFrame(8'h55, 1'b0);
        waitDrain(100);

        $display("[TB] read access while idle");
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("idleReadLevel", 32'(tx_level), 32'd0);
        checkOutput("idleReadTxd",   32'(txd),      32'd1);
        checkOutput("idleReadBusy",  32'(tx_busy),  32'd0);

        $display("[TB] fill FIFO behind a running frame");
        applyStimulus(1'b1, 8'hA0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("levelAfterFirstPop", 32'(tx_level), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 8'hA0 + 8'(i), 1'b0);
        end
        checkOutput("levelFull", 32'(tx_level), 32'd8);
        applyStimulus(1'b1, 8'hEE, 1'b1);
        checkOutput("levelAfterOverflow", 32'(tx_level), 32'd8);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("levelAfterRead", 32'(tx_level), 32'd8);
        checkOutput("busyAfterRead",  32'(tx_busy),  32'd1);
        waitDrain(9 * FRAME_CYC + 100);

        $display("[TB] back-to-back frames 0xA3, 0x3C");
        applyStimulus(1'b1, 8'hA3, 1'b0);
        applyStimulus(1'b1, 8'h3C, 1'b0);
        for (int t = 0; t < 2 * FRAME_CYC + 10; t++) begin
            @(posedge clk);
            #1;
            tr[t] = txd;
        end
        f1 = -1;
        for (int t = 0; t < 2 * FRAME_CYC + 10; t++) begin
            if (f1 < 0 && tr[t] === 1'b0) f1 = t;
        end
        checkOutput("b2bFirstStart", 32'(f1), 32'd0);
        if (f1 < 0) f1 = 0;
        checkOutput("b2bStopBeforeStart", 32'(tr[f1 + FRAME_CYC - 1]), 32'd1);
        checkOutput("b2bSecondStart",     32'(tr[f1 + FRAME_CYC]),     32'd0);
        waitDrain(2 * FRAME_CYC + 100);

        $display("[TB] parity-bit frames 0x07, 0x03");
        traceFrame(8'h07, 1'b1);
        waitDrain(100);
        traceFrame(8'h03, 1'b0);
        waitDrain(100);

        $display("[TB] reset during data bit 3");
        applyStimulus(1'b1, 8'h33, 1'b0);
        applyStimulus(1'b1, 8'hC4, 1'b0);
        repeat (18) @(posedge clk);
        #1;
        checkOutput("preResetTxdBit3", 32'(txd),      32'd0);
        checkOutput("preResetLevel",   32'(tx_level), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midResetTxd",   32'(txd),      32'd1);
        checkOutput("midResetLevel", 32'(tx_level), 32'd0);
        checkOutput("midResetBusy",  32'(tx_busy),  32'd0);
        expQ.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, 8'h96, 1'b0);
        checkOutput("postResetLevel", 32'(tx_level), 32'd1);
        waitDrain(FRAME_CYC + 100);

        checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
